// File: rtl/writeback_unit.sv
// Write-back stage: 2-entry retire FIFO, result select/extension, registered register-file write port, in-flight scoreboard.
// Optional retired-instruction counter output enabled by defining WB_INSTRET_EN.
module writeback_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic             mem_reg_write,
   input  logic [4:0]       mem_rd_addr,
   input  logic [1:0]       mem_wb_sel,
   input  logic [2:0]       mem_funct3,
   input  logic [WIDTH-1:0] mem_alu_result,
   input  logic [WIDTH-1:0] mem_load_data,
   input  logic [WIDTH-1:0] mem_pc_plus4,
   input  logic             wb_hold,
   output logic             wb_write_enable,
   output logic [4:0]       wb_rd_addr,
   output logic [WIDTH-1:0] wb_write_data,
   input  logic             dec_issue_valid,
   input  logic [4:0]       dec_issue_rd,
   output logic             dec_issue_ready,
   input  logic [4:0]       dec_rs1_addr,
   input  logic [4:0]       dec_rs2_addr,
   output logic             dec_rs1_pending,
   output logic             dec_rs2_pending
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]      instret
`endif
);

   logic             rw_q   [2];
   logic [4:0]       rd_q   [2];
   logic [1:0]       sel_q  [2];
   logic [2:0]       f3_q   [2];
   logic [WIDTH-1:0] alu_q  [2];
   logic [WIDTH-1:0] load_q [2];
   logic [WIDTH-1:0] pc4_q  [2];

   logic       head;
   logic       tail;
   logic [1:0] count;
   logic       push;
   logic       pop;
   logic       head_writes;

   logic [WIDTH-1:0] head_val;
   logic [WIDTH-1:0] ld;

   logic [1:0]  sb_cnt [32];
   logic [31:0] sb_inc;
   logic [31:0] sb_dec;
   logic        issue_fire;

   assign mem_ready   = (count != 2'd2);
   assign push        = mem_valid && mem_ready;
   assign pop         = (count != 2'd0) && !wb_hold;
   assign head_writes = rw_q[head] && (rd_q[head] != 5'd0);

   always_ff @(posedge clk) begin
      if (push) begin
         rw_q[tail]   <= mem_reg_write;
         rd_q[tail]   <= mem_rd_addr;
         sel_q[tail]  <= mem_wb_sel;
         f3_q[tail]   <= mem_funct3;
         alu_q[tail]  <= mem_alu_result;
         load_q[tail] <= mem_load_data;
         pc4_q[tail]  <= mem_pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   always_comb begin
      ld       = load_q[head];
      head_val = alu_q[head];
      case (sel_q[head])
         2'b10: head_val = pc4_q[head];
         2'b01: begin
            case (f3_q[head])
               3'b000:  head_val = {{(WIDTH-8){ld[7]}}, ld[7:0]};
               3'b001:  head_val = {{(WIDTH-16){ld[15]}}, ld[15:0]};
               3'b100:  head_val = {{(WIDTH-8){1'b0}}, ld[7:0]};
               3'b101:  head_val = {{(WIDTH-16){1'b0}}, ld[15:0]};
               default: head_val = ld;
            endcase
         end
         default: head_val = alu_q[head];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         wb_write_enable <= 1'b0;
         wb_rd_addr      <= 5'd0;
         wb_write_data   <= '0;
      end else if (pop) begin
         wb_write_enable <= head_writes;
         wb_rd_addr      <= rd_q[head];
         wb_write_data   <= head_val;
      end else begin
         wb_write_enable <= 1'b0;
      end
   end

`ifdef WB_INSTRET_EN
   always_ff @(posedge clk) begin
      if (rst_i)    instret <= 64'd0;
      else if (pop) instret <= instret + 64'd1;
   end
`endif

   // Decrement is taken at the pop edge, the same edge that raises wb_write_enable.
   assign dec_issue_ready = (sb_cnt[dec_issue_rd] != 2'd3);
   assign issue_fire      = dec_issue_valid && dec_issue_ready && (dec_issue_rd != 5'd0);

   always_comb begin
      sb_inc = '0;
      sb_dec = '0;
      if (issue_fire)          sb_inc[dec_issue_rd] = 1'b1;
      if (pop && head_writes)  sb_dec[rd_q[head]]   = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         for (int r = 0; r < 32; r++) sb_cnt[r] <= 2'd0;
      end else begin
         sb_cnt[0] <= 2'd0;
         for (int r = 1; r < 32; r++) begin
            if (sb_inc[r] && !sb_dec[r])
               sb_cnt[r] <= sb_cnt[r] + 2'd1;
            else if (sb_dec[r] && !sb_inc[r] && sb_cnt[r] != 2'd0)
               sb_cnt[r] <= sb_cnt[r] - 2'd1;
         end
      end
   end

   assign dec_rs1_pending = (dec_rs1_addr != 5'd0) && (sb_cnt[dec_rs1_addr] != 2'd0);
   assign dec_rs2_pending = (dec_rs2_addr != 5'd0) && (sb_cnt[dec_rs2_addr] != 2'd0);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit; instret checks active when WB_INSTRET_EN is defined.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_reg_write;
   logic [4:0]  mem_rd_addr;
   logic [1:0]  mem_wb_sel;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_load_data;
   logic [31:0] mem_pc_plus4;
   logic        wb_hold;
   logic        wb_write_enable;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_write_data;
   logic        dec_issue_valid;
   logic [4:0]  dec_issue_rd;
   logic        dec_issue_ready;
   logic [4:0]  dec_rs1_addr;
   logic [4:0]  dec_rs2_addr;
   logic        dec_rs1_pending;
   logic        dec_rs2_pending;
`ifdef WB_INSTRET_EN
   logic [63:0] instret;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   writeback_unit #(.WIDTH(32)) dut (
      .clk             (clk),
      .rst_i           (rst_i),
      .mem_valid       (mem_valid),
      .mem_ready       (mem_ready),
      .mem_reg_write   (mem_reg_write),
      .mem_rd_addr     (mem_rd_addr),
      .mem_wb_sel      (mem_wb_sel),
      .mem_funct3      (mem_funct3),
      .mem_alu_result  (mem_alu_result),
      .mem_load_data   (mem_load_data),
      .mem_pc_plus4    (mem_pc_plus4),
      .wb_hold         (wb_hold),
      .wb_write_enable (wb_write_enable),
      .wb_rd_addr      (wb_rd_addr),
      .wb_write_data   (wb_write_data),
      .dec_issue_valid (dec_issue_valid),
      .dec_issue_rd    (dec_issue_rd),
      .dec_issue_ready (dec_issue_ready),
      .dec_rs1_addr    (dec_rs1_addr),
      .dec_rs2_addr    (dec_rs2_addr),
      .dec_rs1_pending (dec_rs1_pending),
      .dec_rs2_pending (dec_rs2_pending)
`ifdef WB_INSTRET_EN
      ,
      .instret         (instret)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_entry(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [31:0] alu,
                              input logic [31:0] ldd, input logic [31:0] pc4);
      mem_valid      = 1'b1;
      mem_reg_write  = rw;
      mem_rd_addr    = rd;
      mem_wb_sel     = sel;
      mem_funct3     = f3;
      mem_alu_result = alu;
      mem_load_data  = ldd;
      mem_pc_plus4   = pc4;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step();
      step();
      dec_rs1_addr = 5'd7;
      dec_rs2_addr = 5'd31;
      #1;
      total++;
      if (mem_ready !== 1'b1 || wb_write_enable !== 1'b0 || wb_rd_addr !== 5'd0 ||
          wb_write_data !== 32'd0 || dec_issue_ready !== 1'b1 ||
          dec_rs1_pending !== 1'b0 || dec_rs2_pending !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: rdy=%b we=%b rd=%0d data=%h irdy=%b p1=%b p2=%b, need 1 0 0 0 1 0 0",
                  mem_ready, wb_write_enable, wb_rd_addr, wb_write_data, dec_issue_ready,
                  dec_rs1_pending, dec_rs2_pending);
      end
`ifdef WB_INSTRET_EN
      total++;
      if (instret !== 64'd0) begin
         bad++;
         $display("FAIL reset_instret: got %0d need 0", instret);
      end
`endif
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_no_write();
      drive_entry(1'b1, 5'd0, 2'b00, 3'b000, 32'hDEAD_0000, 32'd0, 32'd0);
      step();
      drive_entry(1'b0, 5'd3, 2'b00, 3'b000, 32'hBEEF_0003, 32'd0, 32'd0);
      step();
      mem_valid = 1'b0;
      total++;
      if (wb_write_enable !== 1'b0 || wb_rd_addr !== 5'd0) begin
         bad++;
         $display("FAIL nowrite_rd0: we=%b rd=%0d need we=0 rd=0", wb_write_enable, wb_rd_addr);
      end
      step();
      total++;
      if (wb_write_enable !== 1'b0 || wb_rd_addr !== 5'd3 || wb_write_data !== 32'hBEEF_0003) begin
         bad++;
         $display("FAIL nowrite_rw0: we=%b rd=%0d data=%h need we=0 rd=3 data=beef0003",
                  wb_write_enable, wb_rd_addr, wb_write_data);
      end
`ifdef WB_INSTRET_EN
      total++;
      if (instret !== 64'd2) begin
         bad++;
         $display("FAIL nowrite_instret: got %0d need 2", instret);
      end
`endif
      step();
   endtask

   task automatic test_alu();
      drive_entry(1'b1, 5'd5, 2'b00, 3'b000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0004);
      step();
      mem_valid = 1'b0;
      total++;
      if (wb_write_enable !== 1'b0) begin
         bad++;
         $display("FAIL alu_latency: we=%b one cycle after push, need 0", wb_write_enable);
      end
      step();
      total++;
      if (wb_write_enable !== 1'b1 || wb_rd_addr !== 5'd5 || wb_write_data !== 32'h1234_5678) begin
         bad++;
         $display("FAIL alu_write: we=%b rd=%0d data=%h need 1 5 12345678",
                  wb_write_enable, wb_rd_addr, wb_write_data);
      end
      step();
      total++;
      if (wb_write_enable !== 1'b0 || wb_rd_addr !== 5'd5 || wb_write_data !== 32'h1234_5678) begin
         bad++;
         $display("FAIL alu_hold: we=%b rd=%0d data=%h need 0 5 12345678",
                  wb_write_enable, wb_rd_addr, wb_write_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  sel [7];
      logic [2:0]  f3  [7];
      logic [31:0] exp [7];
      sel[0] = 2'b01; f3[0] = 3'b000; exp[0] = 32'hFFFF_FF80;
      sel[1] = 2'b01; f3[1] = 3'b100; exp[1] = 32'h0000_0080;
      sel[2] = 2'b01; f3[2] = 3'b001; exp[2] = 32'hFFFF_8080;
      sel[3] = 2'b01; f3[3] = 3'b101; exp[3] = 32'h0000_8080;
      sel[4] = 2'b01; f3[4] = 3'b010; exp[4] = 32'h0000_8080;
      sel[5] = 2'b10; f3[5] = 3'b000; exp[5] = 32'h0000_1004;
      sel[6] = 2'b11; f3[6] = 3'b001; exp[6] = 32'hA5A5_0006;
      for (int i = 0; i <= 7; i++) begin
         if (i < 7)
            drive_entry(1'b1, 5'(10 + i), sel[i], f3[i], 32'hA5A5_0000 + 32'(i),
                        32'h0000_8080, 32'h0000_1004);
         else
            mem_valid = 1'b0;
         step();
         if (i >= 1) begin
            total++;
            if (wb_write_enable !== 1'b1 || wb_rd_addr !== 5'(9 + i) || wb_write_data !== exp[i-1]) begin
               bad++;
               $display("FAIL select_%0d: we=%b rd=%0d data=%h need 1 %0d %h",
                        i - 1, wb_write_enable, wb_rd_addr, wb_write_data, 9 + i, exp[i-1]);
            end
         end
      end
      step();
   endtask

   task automatic test_hold();
      wb_hold = 1'b1;
      drive_entry(1'b1, 5'd11, 2'b00, 3'b000, 32'h0000_00A1, 32'd0, 32'd0);
      step();
      drive_entry(1'b1, 5'd12, 2'b00, 3'b000, 32'h0000_00B2, 32'd0, 32'd0);
      total++;
      if (mem_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_ready1: mem_ready=%b need 1", mem_ready);
      end
      step();
      drive_entry(1'b1, 5'd13, 2'b00, 3'b000, 32'h0000_00C3, 32'd0, 32'd0);
      total++;
      if (mem_ready !== 1'b0 || wb_write_enable !== 1'b0) begin
         bad++;
         $display("FAIL hold_full: mem_ready=%b we=%b need 0 0", mem_ready, wb_write_enable);
      end
      step();
      mem_valid = 1'b0;
      wb_hold   = 1'b0;
      step();
      total++;
      if (wb_write_enable !== 1'b1 || wb_rd_addr !== 5'd11 || wb_write_data !== 32'h0000_00A1) begin
         bad++;
         $display("FAIL hold_first: we=%b rd=%0d data=%h need 1 11 000000a1",
                  wb_write_enable, wb_rd_addr, wb_write_data);
      end
      step();
      total++;
      if (wb_write_enable !== 1'b1 || wb_rd_addr !== 5'd12 || wb_write_data !== 32'h0000_00B2 ||
          mem_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_second: we=%b rd=%0d data=%h rdy=%b need 1 12 000000b2 1",
                  wb_write_enable, wb_rd_addr, wb_write_data, mem_ready);
      end
      step();
      total++;
      if (wb_write_enable !== 1'b0) begin
         bad++;
         $display("FAIL hold_refused: we=%b need 0 (third entry must not be accepted)", wb_write_enable);
      end
   endtask

   task automatic test_scoreboard();
      dec_rs1_addr    = 5'd7;
      dec_rs2_addr    = 5'd8;
      dec_issue_rd    = 5'd7;
      dec_issue_valid = 1'b1;
      step();
      step();
      dec_issue_valid = 1'b0;
      total++;
      if (dec_issue_ready !== 1'b1 || dec_rs1_pending !== 1'b1 || dec_rs2_pending !== 1'b0) begin
         bad++;
         $display("FAIL sb_two: irdy=%b p1=%b p2=%b need 1 1 0", dec_issue_ready, dec_rs1_pending,
                  dec_rs2_pending);
      end
      drive_entry(1'b1, 5'd7, 2'b00, 3'b000, 32'h0000_0777, 32'd0, 32'd0);
      step();
      mem_valid       = 1'b0;
      dec_issue_valid = 1'b1;
      step();
      total++;
      if (wb_write_enable !== 1'b1 || wb_rd_addr !== 5'd7 || dec_issue_ready !== 1'b1) begin
         bad++;
         $display("FAIL sb_same_cycle: we=%b rd=%0d irdy=%b need 1 7 1", wb_write_enable, wb_rd_addr,
                  dec_issue_ready);
      end
      step();
      total++;
      if (dec_issue_ready !== 1'b0 || dec_rs1_pending !== 1'b1) begin
         bad++;
         $display("FAIL sb_full: irdy=%b p1=%b need 0 1", dec_issue_ready, dec_rs1_pending);
      end
      step();
      dec_issue_valid = 1'b0;
      dec_issue_rd    = 5'd8;
      #1;
      total++;
      if (dec_issue_ready !== 1'b1) begin
         bad++;
         $display("FAIL sb_other_rd: irdy=%b for rd=8 need 1", dec_issue_ready);
      end
      dec_issue_rd = 5'd7;
      for (int i = 0; i < 3; i++) begin
         drive_entry(1'b1, 5'd7, 2'b00, 3'b000, 32'h0000_0700 + 32'(i), 32'd0, 32'd0);
         step();
      end
      mem_valid = 1'b0;
      total++;
      if (dec_rs1_pending !== 1'b1 || dec_issue_ready !== 1'b1) begin
         bad++;
         $display("FAIL sb_one_left: p1=%b irdy=%b need 1 1", dec_rs1_pending, dec_issue_ready);
      end
      step();
      total++;
      if (dec_rs1_pending !== 1'b0 || wb_write_enable !== 1'b1) begin
         bad++;
         $display("FAIL sb_drained: p1=%b we=%b need 0 1", dec_rs1_pending, wb_write_enable);
      end
      dec_rs1_addr = 5'd0;
      #1;
      total++;
      if (dec_rs1_pending !== 1'b0) begin
         bad++;
         $display("FAIL sb_x0: p1=%b need 0", dec_rs1_pending);
      end
      step();
   endtask

   task automatic test_reset_mid();
      wb_hold         = 1'b1;
      dec_issue_rd    = 5'd9;
      dec_issue_valid = 1'b1;
      dec_rs1_addr    = 5'd9;
      drive_entry(1'b1, 5'd9, 2'b00, 3'b000, 32'h0000_0999, 32'd0, 32'd0);
      step();
      dec_issue_valid = 1'b0;
      drive_entry(1'b1, 5'd10, 2'b00, 3'b000, 32'h0000_0AAA, 32'd0, 32'd0);
      step();
      mem_valid = 1'b0;
      total++;
      if (mem_ready !== 1'b0 || dec_rs1_pending !== 1'b1) begin
         bad++;
         $display("FAIL mid_setup: rdy=%b p1=%b need 0 1", mem_ready, dec_rs1_pending);
      end
      rst_i   = 1'b1;
      wb_hold = 1'b0;
      step();
      total++;
      if (mem_ready !== 1'b1 || wb_write_enable !== 1'b0 || wb_rd_addr !== 5'd0 ||
          wb_write_data !== 32'd0 || dec_rs1_pending !== 1'b0 || dec_issue_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset: rdy=%b we=%b rd=%0d data=%h p1=%b irdy=%b need 1 0 0 0 0 1",
                  mem_ready, wb_write_enable, wb_rd_addr, wb_write_data, dec_rs1_pending,
                  dec_issue_ready);
      end
`ifdef WB_INSTRET_EN
      total++;
      if (instret !== 64'd0) begin
         bad++;
         $display("FAIL mid_instret: got %0d need 0", instret);
      end
`endif
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (wb_write_enable !== 1'b0 || wb_rd_addr !== 5'd0) begin
            bad++;
            $display("FAIL mid_after_%0d: we=%b rd=%0d need 0 0", i, wb_write_enable, wb_rd_addr);
         end
      end
   endtask

   initial begin
      rst_i           = 1'b1;
      mem_valid       = 1'b0;
      mem_reg_write   = 1'b0;
      mem_rd_addr     = 5'd0;
      mem_wb_sel      = 2'b00;
      mem_funct3      = 3'b000;
      mem_alu_result  = 32'd0;
      mem_load_data   = 32'd0;
      mem_pc_plus4    = 32'd0;
      wb_hold         = 1'b0;
      dec_issue_valid = 1'b0;
      dec_issue_rd    = 5'd0;
      dec_rs1_addr    = 5'd0;
      dec_rs2_addr    = 5'd0;

      test_reset();
      test_no_write();
      test_alu();
      test_back_to_back();
      test_hold();
      test_scoreboard();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
